// File: rtl/mem_arbiter.sv
// Main-memory arbiter and block-fill sequencer shared by the I-side fill, D-side fill and D-side stores.
// Define MEM_ARB_FAIR_EN to let a waiting I-side fill win over D-side traffic after any D-side grant.
module mem_arbiter #(
    parameter int MEM_LATENCY = 4,
    parameter int BLOCK_WORDS = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           I_fill_req,
    input  logic [15:0]                    I_fill_addr,
    input  logic                           D_fill_req,
    input  logic [15:0]                    D_fill_addr,
    input  logic                           D_write_req,
    input  logic [15:0]                    D_write_addr,
    input  logic [15:0]                    D_write_data,
    output logic                           mem_en,
    output logic                           mem_wr,
    output logic [15:0]                    mem_addr,
    output logic [15:0]                    mem_data_in,
    input  logic [15:0]                    mem_data_out,
    input  logic                           mem_data_valid,
    output logic [15:0]                    fill_data,
    output logic [$clog2(BLOCK_WORDS)-1:0] fill_word,
    output logic                           I_fill_we,
    output logic                           D_fill_we,
    output logic                           I_fill_done,
    output logic                           D_fill_done,
    output logic                           D_write_done,
    output logic                           busy
);

    localparam int          WORD_BITS   = $clog2(BLOCK_WORDS);
    localparam logic [15:0] OFFSET_MASK = 16'(2 * BLOCK_WORDS - 1);

    typedef enum logic [1:0] {IDLE, WRITE, I_FILL, D_FILL} state_t;

    state_t                 state, next_state;
    logic [WORD_BITS:0]     issue_cnt;
    logic [WORD_BITS-1:0]   recv_cnt;
    logic [15:0]            base;
    logic [MEM_LATENCY-1:0] inflight;
    logic                   in_fill, issue, accept, last_word, turnaround, favour_i;

    // A return is only accepted if this fill issued a read exactly MEM_LATENCY cycles ago,
    // so words still in flight from a transaction killed by reset are dropped.
    assign in_fill    = (state == I_FILL) || (state == D_FILL);
    assign issue      = in_fill && (issue_cnt < (WORD_BITS+1)'(BLOCK_WORDS));
    assign accept     = in_fill && mem_data_valid && inflight[MEM_LATENCY-1];
    assign last_word  = accept && (recv_cnt == WORD_BITS'(BLOCK_WORDS - 1));
    assign turnaround = I_fill_done || D_fill_done || D_write_done;

`ifdef MEM_ARB_FAIR_EN
    logic last_D;
    assign favour_i = last_D;
`else
    assign favour_i = 1'b0;
`endif

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                // Requesters still hold their request during the done pulse; ignore it then.
                if (!turnaround) begin
                    if (I_fill_req && favour_i) next_state = I_FILL;
                    else if (D_write_req)       next_state = WRITE;
                    else if (D_fill_req)        next_state = D_FILL;
                    else if (I_fill_req)        next_state = I_FILL;
                end
            end
            WRITE:          next_state = IDLE;
            I_FILL, D_FILL: if (last_word) next_state = IDLE;
            default:        next_state = IDLE;
        endcase
    end

    always_comb begin
        mem_en      = 1'b0;
        mem_wr      = 1'b0;
        mem_addr    = '0;
        mem_data_in = '0;
        if (state == WRITE) begin
            mem_en      = 1'b1;
            mem_wr      = 1'b1;
            mem_addr    = D_write_addr;
            mem_data_in = D_write_data;
        end else if (issue) begin
            mem_en   = 1'b1;
            mem_addr = base | 16'({issue_cnt[WORD_BITS-1:0], 1'b0});
        end
    end

    assign fill_data = accept ? mem_data_out : '0;
    assign fill_word = recv_cnt;
    assign I_fill_we = accept && (state == I_FILL);
    assign D_fill_we = accept && (state == D_FILL);
    assign busy      = (state != IDLE);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            issue_cnt    <= '0;
            recv_cnt     <= '0;
            base         <= '0;
            inflight     <= '0;
            I_fill_done  <= 1'b0;
            D_fill_done  <= 1'b0;
            D_write_done <= 1'b0;
`ifdef MEM_ARB_FAIR_EN
            last_D       <= 1'b0;
`endif
        end else begin
            state        <= next_state;
            I_fill_done  <= (state == I_FILL) && last_word;
            D_fill_done  <= (state == D_FILL) && last_word;
            D_write_done <= (state == WRITE);

            inflight[0] <= issue;
            for (int i = 1; i < MEM_LATENCY; i++) inflight[i] <= inflight[i-1];

            if (state == IDLE) begin
                issue_cnt <= '0;
                recv_cnt  <= '0;
                if (next_state == I_FILL)      base <= I_fill_addr & ~OFFSET_MASK;
                else if (next_state == D_FILL) base <= D_fill_addr & ~OFFSET_MASK;
`ifdef MEM_ARB_FAIR_EN
                if (next_state != IDLE) last_D <= (next_state != I_FILL);
`endif
            end else begin
                if (issue)  issue_cnt <= issue_cnt + 1'b1;
                if (accept) recv_cnt  <= recv_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: default instance (latency 4, 8 words) and a minimal one (latency 1, 2 words).
// Expected issues, fill writes and done pulses are queued by the stimulus and popped by a monitor at negedge.
module tb_mem_arbiter;

    localparam int L0 = 4, B0 = 8, L1 = 1, B1 = 2;

    logic        clk, rst;
    logic        i_req[2], d_req[2], w_req[2];
    logic [15:0] i_addr[2], d_addr[2], w_addr[2], w_data[2];
    logic        mem_en[2], mem_wr[2], mdv[2];
    logic [15:0] mem_addr[2], mem_din[2], mdo[2], fill_data[2];
    logic [2:0]  fw0;
    logic [0:0]  fw1;
    logic [3:0]  fword[2];
    logic        ifwe[2], dfwe[2], idone[2], ddone[2], wdone[2], busy[2];

    assign fword[0] = {1'b0, fw0};
    assign fword[1] = {3'b000, fw1};

    mem_arbiter #(.MEM_LATENCY(L0), .BLOCK_WORDS(B0)) u_dut0 (
        .clk(clk), .rst(rst),
        .I_fill_req(i_req[0]), .I_fill_addr(i_addr[0]),
        .D_fill_req(d_req[0]), .D_fill_addr(d_addr[0]),
        .D_write_req(w_req[0]), .D_write_addr(w_addr[0]), .D_write_data(w_data[0]),
        .mem_en(mem_en[0]), .mem_wr(mem_wr[0]), .mem_addr(mem_addr[0]), .mem_data_in(mem_din[0]),
        .mem_data_out(mdo[0]), .mem_data_valid(mdv[0]),
        .fill_data(fill_data[0]), .fill_word(fw0),
        .I_fill_we(ifwe[0]), .D_fill_we(dfwe[0]),
        .I_fill_done(idone[0]), .D_fill_done(ddone[0]), .D_write_done(wdone[0]),
        .busy(busy[0])
    );

    mem_arbiter #(.MEM_LATENCY(L1), .BLOCK_WORDS(B1)) u_dut1 (
        .clk(clk), .rst(rst),
        .I_fill_req(i_req[1]), .I_fill_addr(i_addr[1]),
        .D_fill_req(d_req[1]), .D_fill_addr(d_addr[1]),
        .D_write_req(w_req[1]), .D_write_addr(w_addr[1]), .D_write_data(w_data[1]),
        .mem_en(mem_en[1]), .mem_wr(mem_wr[1]), .mem_addr(mem_addr[1]), .mem_data_in(mem_din[1]),
        .mem_data_out(mdo[1]), .mem_data_valid(mdv[1]),
        .fill_data(fill_data[1]), .fill_word(fw1),
        .I_fill_we(ifwe[1]), .D_fill_we(dfwe[1]),
        .I_fill_done(idone[1]), .D_fill_done(ddone[1]), .D_write_done(wdone[1]),
        .busy(busy[1])
    );

    typedef struct {
        int dut;
        int cyc;
        int a;   // issue: wr flag | fill: side (0 I, 1 D) | done: kind (0 I, 1 D, 2 write)
        int b;   // issue: address | fill: word index
        int c;   // issue: write data | fill: data
    } exp_t;

    exp_t iss_q[$], fill_q[$], done_q[$];
    int   cyc, n_checks, n_fail;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation still running at cycle %0d, required to have finished", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic spurious(input string name, input int d, input int val);
        n_checks++;
        n_fail++;
        $display("FAIL %s: dut%0d asserted with value 0x%0h at cycle %0d, required nothing", name, d, val, cyc);
    endtask

    // Expected traffic of one fill: word k issued in F0+k, written in F0+k+lat, done in F0+bw+lat.
    task automatic push_fill(input int d, input int side, input int addr, input int f0,
                             input int lat, input int bw, input int n_iss, input int n_fil,
                             input bit with_done, output int done_c);
        int base;
        base = addr & ~(2 * bw - 1) & 16'hFFFF;
        for (int k = 0; k < n_iss; k++) iss_q.push_back('{d, f0 + k, 0, base + 2 * k, 0});
        for (int k = 0; k < n_fil; k++)
            fill_q.push_back('{d, f0 + k + lat, side, k, (base + 2 * k) ^ 16'hA5A5});
        done_c = f0 + bw - 1 + lat + 1;
        if (with_done) done_q.push_back('{d, done_c, side, 0, 0});
    endtask

    task automatic at_cycle(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_req(input int d, input int side, input logic val);
        if (side == 0) i_req[d] = val;
        else           d_req[d] = val;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_mem_en"},    mem_en[0],    0);
        check({tag, "_mem_wr"},    mem_wr[0],    0);
        check({tag, "_mem_addr"},  mem_addr[0],  0);
        check({tag, "_mem_din"},   mem_din[0],   0);
        check({tag, "_fill_data"}, fill_data[0], 0);
        check({tag, "_fill_word"}, fword[0],     0);
        check({tag, "_I_fill_we"}, ifwe[0],      0);
        check({tag, "_D_fill_we"}, dfwe[0],      0);
        check({tag, "_I_done"},    idone[0],     0);
        check({tag, "_D_done"},    ddone[0],     0);
        check({tag, "_W_done"},    wdone[0],     0);
        check({tag, "_busy"},      busy[0],      0);
    endtask

    // Pipelined memory: data = address ^ 0xA5A5, returned exactly MEM_LATENCY cycles after the read.
    initial begin
        logic        pv[2][8];
        logic [15:0] pa[2][8];
        logic        cv[2];
        logic [15:0] ca[2];
        int          lat;
        for (int d = 0; d < 2; d++) begin
            mdv[d] = 1'b0;
            mdo[d] = '0;
            for (int j = 0; j < 8; j++) begin
                pv[d][j] = 1'b0;
                pa[d][j] = '0;
            end
        end
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                cv[d] = mem_en[d] && !mem_wr[d];
                ca[d] = mem_addr[d];
            end
            @(posedge clk);
            #1;
            for (int d = 0; d < 2; d++) begin
                for (int j = 7; j > 0; j--) begin
                    pv[d][j] = pv[d][j-1];
                    pa[d][j] = pa[d][j-1];
                end
                pv[d][0] = cv[d];
                pa[d][0] = ca[d];
                lat      = (d == 0) ? L0 : L1;
                mdv[d]   = pv[d][lat-1];
                mdo[d]   = pv[d][lat-1] ? (pa[d][lat-1] ^ 16'hA5A5) : 16'h0000;
            end
        end
    end

    task automatic pop_done(input int d, input int kind);
        exp_t e;
        if (done_q.size() == 0) spurious("done", d, kind);
        else begin
            e = done_q.pop_front();
            check("done_dut",   d,    e.dut);
            check("done_cycle", cyc,  e.cyc);
            check("done_kind",  kind, e.a);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (mem_en[d]) begin
                    if (iss_q.size() == 0) spurious("issue", d, mem_addr[d]);
                    else begin
                        e = iss_q.pop_front();
                        check("issue_dut",   d,           e.dut);
                        check("issue_cycle", cyc,         e.cyc);
                        check("issue_wr",    mem_wr[d],   e.a);
                        check("issue_addr",  mem_addr[d], e.b);
                        if (e.a != 0) check("write_data", mem_din[d], e.c);
                    end
                end
                if (ifwe[d] || dfwe[d]) begin
                    if (fill_q.size() == 0) spurious("fill_we", d, fill_data[d]);
                    else begin
                        e = fill_q.pop_front();
                        check("fill_dut",   d,            e.dut);
                        check("fill_cycle", cyc,          e.cyc);
                        check("fill_I_we",  ifwe[d],      int'(e.a == 0));
                        check("fill_D_we",  dfwe[d],      int'(e.a == 1));
                        check("fill_word",  fword[d],     e.b);
                        check("fill_data",  fill_data[d], e.c);
                    end
                end
                if (idone[d]) pop_done(d, 0);
                if (ddone[d]) pop_done(d, 1);
                if (wdone[d]) pop_done(d, 2);
            end
        end
    end

    initial begin
        int s, dn, dn2, f, side1, side2, addr1, addr2, side;
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        for (int d = 0; d < 2; d++) begin
            i_req[d] = 1'b0; d_req[d] = 1'b0; w_req[d] = 1'b0;
            i_addr[d] = '0; d_addr[d] = '0; w_addr[d] = '0; w_data[d] = '0;
        end

        // Reset state
        at_cycle(2);
        check_idle_outputs("reset");
        check("reset_busy_small", busy[1], 0);
        rst = 1'b0;

        // Lone I fill at 0x1236; address change mid-fill must not move the block
        at_cycle(4);
        i_req[0] = 1'b1; i_addr[0] = 16'h1236;
        push_fill(0, 0, 16'h1236, 5, L0, B0, B0, B0, 1'b1, dn);
        at_cycle(7);
        i_addr[0] = 16'hFFFF;
        at_cycle(dn + 1);
        i_req[0] = 1'b0;

        // Store, D fill and I fill requested together
        s = dn + 3;
        at_cycle(s);
        w_req[0] = 1'b1; w_addr[0] = 16'h2000; w_data[0] = 16'hBEEF;
        d_req[0] = 1'b1; d_addr[0] = 16'h3457;
        i_req[0] = 1'b1; i_addr[0] = 16'h4000;
        iss_q.push_back('{0, s + 1, 1, 16'h2000, 16'hBEEF});
        done_q.push_back('{0, s + 2, 2, 0, 0});
`ifdef MEM_ARB_FAIR_EN
        side1 = 0; addr1 = 16'h4000; side2 = 1; addr2 = 16'h3457;
`else
        side1 = 1; addr1 = 16'h3457; side2 = 0; addr2 = 16'h4000;
`endif
        push_fill(0, side1, addr1, s + 4, L0, B0, B0, B0, 1'b1, dn);
        push_fill(0, side2, addr2, dn + 2, L0, B0, B0, B0, 1'b1, dn2);
        at_cycle(s + 3);
        w_req[0] = 1'b0;
        at_cycle(dn + 1);
        set_req(0, side1, 1'b0);
        at_cycle(dn2 + 1);
        set_req(0, side2, 1'b0);

        // Reset in F6 of a D fill, then an I fill that must ignore the stale returns
        s = dn2 + 3;
        at_cycle(s);
        d_req[0] = 1'b1; d_addr[0] = 16'h5000;
        push_fill(0, 1, 16'h5000, s + 1, L0, B0, 7, 3, 1'b0, dn);
        at_cycle(s + 7);
        rst = 1'b1;
        at_cycle(s + 8);
        rst = 1'b0;
        d_req[0] = 1'b0;
        i_req[0] = 1'b1; i_addr[0] = 16'h6000;
        #1;
        check_idle_outputs("after_rst");
        push_fill(0, 0, 16'h6000, s + 9, L0, B0, B0, B0, 1'b1, dn);
        at_cycle(dn + 1);
        i_req[0] = 1'b0;

        // D fill and I fill held continuously for three grants
        s = dn + 3;
        at_cycle(s);
        d_req[0] = 1'b1; d_addr[0] = 16'h7000;
        i_req[0] = 1'b1; i_addr[0] = 16'h8000;
        f = s + 1;
        for (int g = 0; g < 3; g++) begin
`ifdef MEM_ARB_FAIR_EN
            side = (g % 2 == 0) ? 1 : 0;
`else
            side = 1;
`endif
            push_fill(0, side, (side == 1) ? 16'h7000 : 16'h8000, f, L0, B0, B0, B0, 1'b1, dn);
            f = dn + 2;
        end
        at_cycle(dn + 1);
        d_req[0] = 1'b0;
        i_req[0] = 1'b0;

        // Minimal configuration: latency 1, two-word blocks, addr 0x00FF
        s = dn + 3;
        at_cycle(s);
        i_req[1] = 1'b1; i_addr[1] = 16'h00FF;
        push_fill(1, 0, 16'h00FF, s + 1, L1, B1, B1, B1, 1'b1, dn);
        at_cycle(dn + 1);
        i_req[1] = 1'b0;

        at_cycle(dn + 8);
        check("leftover_issues", iss_q.size(),  0);
        check("leftover_fills",  fill_q.size(), 0);
        check("leftover_dones",  done_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
